// File: rtl/issue_ls.sv
// Load/store issue-and-execute stage: one memory op at a time,
// req/ack data-memory access, load results broadcast on the CDB.
module issue_ls #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issuels_opcode,
  input  logic [5:0]  issuels_rdtag,
  input  logic [31:0] issuels_addr,
  input  logic [31:0] issuels_data,
  input  logic        issuels_ready,
  output logic        issuels_done,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic [5:0]  cdb_out_tag,
  output logic [31:0] cdb_out_data,
  output logic        ls_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [5:0]         tag_q, tag_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (issuels_ready) begin
          op_d    = issuels_opcode;
          tag_d   = issuels_rdtag;
          addr_d  = issuels_addr;
          data_d  = issuels_data;
          cnt_d   = '0;
          state_d = MEM;
        end
      end
      MEM: begin
        // ack beats the timeout threshold in the same cycle
        if (dmem_ack) begin
          if (op_q) begin
            data_d  = dmem_rdata;
            state_d = WB;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        if (cdb_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_mem, in_wb;
  assign in_mem = (state_q == MEM);
  assign in_wb  = (state_q == WB);

  assign issuels_done = (state_q == IDLE);
  assign dmem_req     = in_mem;
  assign dmem_we      = in_mem & ~op_q;
  assign dmem_addr    = in_mem ? addr_q : '0;
  assign dmem_wdata   = in_mem ? data_q : '0;
  assign cdb_req      = in_wb;
  assign cdb_out_tag  = in_wb ? tag_q : '0;
  assign cdb_out_data = in_wb ? data_q : '0;
  assign ls_timeout   = to_q;

endmodule

// File: tb/tb_issue_ls.sv
// Bench for issue_ls: directed scenarios plus randomized ops
// checked against a transaction-level timing model.
module tb_issue_ls;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        issuels_opcode;
  logic [5:0]  issuels_rdtag;
  logic [31:0] issuels_addr;
  logic [31:0] issuels_data;
  logic        issuels_ready;
  logic        issuels_done;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        cdb_req;
  logic        cdb_grant;
  logic [5:0]  cdb_out_tag;
  logic [31:0] cdb_out_data;
  logic        ls_timeout;

  int n_vec = 0;
  int n_err = 0;
  bit model_to = 1'b0;

  issue_ls #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .issuels_opcode(issuels_opcode),
    .issuels_rdtag(issuels_rdtag),
    .issuels_addr(issuels_addr),
    .issuels_data(issuels_data),
    .issuels_ready(issuels_ready),
    .issuels_done(issuels_done),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_out_tag(cdb_out_tag), .cdb_out_data(cdb_out_data),
    .ls_timeout(ls_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_checks(input string nm);
    n_vec++;
    if ({issuels_done, dmem_req, dmem_we, cdb_req} !== 4'b1000) begin
      n_err++;
      $display("FAIL %s_ctl got done/req/we/cdb=%b exp 1000", nm,
               {issuels_done, dmem_req, dmem_we, cdb_req});
    end
    n_vec++;
    if ({dmem_addr, dmem_wdata, cdb_out_tag, cdb_out_data} !== '0) begin
      n_err++;
      $display("FAIL %s_zero got addr=%h wd=%h tag=%h cd=%h exp 0", nm,
               dmem_addr, dmem_wdata, cdb_out_tag, cdb_out_data);
    end
    n_vec++;
    if (ls_timeout !== model_to) begin
      n_err++;
      $display("FAIL %s_to got %b exp %b", nm, ls_timeout, model_to);
    end
  endtask

  // lat = wait cycles before ack, gnt = cycles before grant
  task automatic drive_op(input bit op, input logic [5:0] tag,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int lat,
                          input int gnt, input string nm);
    bit acked;
    int req_cyc;
    acked   = (lat < TO);
    req_cyc = acked ? lat + 1 : TO;
    n_vec++;
    if (issuels_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_pre_done got %b exp 1", nm, issuels_done);
    end
    issuels_opcode = op;
    issuels_rdtag  = tag;
    issuels_addr   = a;
    issuels_data   = d;
    issuels_ready  = 1'b1;
    step();
    issuels_ready  = 1'b0;
    issuels_addr   = $urandom;
    issuels_data   = $urandom;
    for (int k = 0; k < req_cyc; k++) begin
      n_vec++;
      if ({dmem_req, dmem_we, issuels_done, cdb_req} !==
          {1'b1, ~op, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL %s_mem%0d got req/we/done/cdb=%b exp %b", nm, k,
                 {dmem_req, dmem_we, issuels_done, cdb_req},
                 {1'b1, ~op, 1'b0, 1'b0});
      end
      n_vec++;
      if (dmem_addr !== a || dmem_wdata !== d) begin
        n_err++;
        $display("FAIL %s_bus%0d got addr=%h wd=%h exp %h %h", nm, k,
                 dmem_addr, dmem_wdata, a, d);
      end
      dmem_ack   = (k == lat);
      dmem_rdata = (k == lat) ? rd : $urandom;
      step();
      dmem_ack   = 1'b0;
    end
    if (!acked) model_to = 1'b1;
    if (acked && op) begin
      for (int g = 0; g <= gnt; g++) begin
        n_vec++;
        if ({cdb_req, dmem_req, issuels_done} !== 3'b100 ||
            cdb_out_tag !== tag || cdb_out_data !== rd) begin
          n_err++;
          $display("FAIL %s_wb%0d got cdb/req/done=%b tag=%h data=%h exp 100 %h %h",
                   nm, g, {cdb_req, dmem_req, issuels_done},
                   cdb_out_tag, cdb_out_data, tag, rd);
        end
        cdb_grant = (g == gnt);
        step();
        cdb_grant = 1'b0;
      end
    end
    idle_checks(nm);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    issuels_opcode = 0; issuels_rdtag = 0; issuels_addr = 0;
    issuels_data = 0; issuels_ready = 0; dmem_rdata = 0;
    dmem_ack = 0; cdb_grant = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_to = 1'b0;
    idle_checks("reset");
  endtask

  task automatic test_store();
    drive_op(1'b0, 6'h00, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0, "store");
  endtask

  task automatic test_load();
    drive_op(1'b1, 6'h2A, 32'h0000_0040, 32'h0, 32'h1234_5678, 3, 2, "load");
  endtask

  task automatic test_back_to_back();
    issuels_opcode = 1'b0; issuels_rdtag = 6'h11;
    issuels_addr = 32'hA000_0000; issuels_data = 32'h5555_AAAA;
    issuels_ready = 1'b1;
    step();
    n_vec++;
    if (!(dmem_req === 1'b1 && dmem_we === 1'b1 &&
          dmem_addr === 32'hA000_0000 && dmem_wdata === 32'h5555_AAAA)) begin
      n_err++;
      $display("FAIL b2b_st got req=%b we=%b addr=%h wd=%h exp 1 1 a0000000 5555aaaa",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    issuels_opcode = 1'b1; issuels_rdtag = 6'h3C;
    issuels_addr = 32'hB000_0008; issuels_data = 32'h0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    n_vec++;
    if (issuels_done !== 1'b1 || dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_gap got done=%b req=%b exp 1 0", issuels_done, dmem_req);
    end
    step();
    issuels_ready = 1'b0;
    n_vec++;
    if (!(dmem_req === 1'b1 && dmem_we === 1'b0 &&
          dmem_addr === 32'hB000_0008)) begin
      n_err++;
      $display("FAIL b2b_ld got req=%b we=%b addr=%h exp 1 0 b0000008",
               dmem_req, dmem_we, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_ack = 1'b0;
    n_vec++;
    if (!(cdb_req === 1'b1 && cdb_out_tag === 6'h3C &&
          cdb_out_data === 32'hCAFE_F00D && dmem_req === 1'b0)) begin
      n_err++;
      $display("FAIL b2b_wb got cdb=%b tag=%h data=%h req=%b exp 1 3c cafef00d 0",
               cdb_req, cdb_out_tag, cdb_out_data, dmem_req);
    end
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    idle_checks("b2b_end");
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 6'h07, 32'h0000_2000, 32'h0, 32'h0, 1000, 0, "tmo_ld");
    drive_op(1'b0, 6'h00, 32'h0000_3000, 32'h0BAD_F00D, 32'h0, 1, 0, "tmo_st");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      drive_op(1'($urandom), 6'($urandom), $urandom, $urandom, $urandom,
               int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
               "rand");
    end
  endtask

  task automatic test_reset_in_wb();
    issuels_opcode = 1'b1; issuels_rdtag = 6'h15;
    issuels_addr = 32'h0000_0100; issuels_ready = 1'b1;
    step();
    issuels_ready = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_0000;
    step();
    dmem_ack = 1'b0;
    n_vec++;
    if (cdb_req !== 1'b1) begin
      n_err++;
      $display("FAIL rstwb_pre got cdb_req=%b exp 1", cdb_req);
    end
    reset = 1'b0;
    step();
    model_to = 1'b0;
    n_vec++;
    if (cdb_req !== 1'b0 || dmem_req !== 1'b0 || ls_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL rstwb_drop got cdb=%b req=%b to=%b exp 0 0 0",
               cdb_req, dmem_req, ls_timeout);
    end
    reset = 1'b1;
    cdb_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (cdb_req !== 1'b0 || cdb_out_tag !== 6'h0) begin
        n_err++;
        $display("FAIL rstwb_post%0d got cdb=%b tag=%h exp 0 0",
                 i, cdb_req, cdb_out_tag);
      end
    end
    cdb_grant = 1'b0;
    idle_checks("rstwb_end");
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_in_wb();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/issue_ls.md
Name: issue_ls

Overview:
- Load/store issue-and-execute stage directly downstream of the load/store issue queue.
- Accepts one ready memory instruction at a time (opcode, destination tag, effective address, store data) and performs the data-memory access over a req/ack handshake.
- For loads, broadcasts the returned word on the common data bus (CDB) through a request/grant arbiter port.
- Raises a sticky error if memory fails to acknowledge within a bounded number of cycles.

Parameters:
- TIMEOUT, 255, max cycles dmem_req may stay high without dmem_ack before the op is aborted (1..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset).
- issuels_opcode  input  1  1 = load, 0 = store.
- issuels_rdtag  input  6  destination tag (loads only).
- issuels_addr  input  32  effective byte address, already offset-added.
- issuels_data  input  32  store data.
- issuels_ready  input  1  queue presents a ready instruction.
- issuels_done  output  1  this block can accept an instruction this cycle.
- dmem_req  output  1  memory access request.
- dmem_we  output  1  1 = write (store), 0 = read (load).
- dmem_addr  output  32  byte address.
- dmem_wdata  output  32  store data.
- dmem_rdata  input  32  load data, valid with dmem_ack.
- dmem_ack  input  1  access complete; sampled only while dmem_req = 1.
- cdb_req  output  1  request CDB slot for load result.
- cdb_grant  input  1  CDB arbiter grant; sampled only while cdb_req = 1.
- cdb_out_tag  output  6  tag broadcast.
- cdb_out_data  output  32  data broadcast.
- ls_timeout  output  1  sticky error: a memory access timed out.

Behaviour:
- Reset (reset = 0 at a rising edge):
  - State goes to IDLE.
  - All latched fields, counter and ls_timeout clear to 0.
  - dmem_req, dmem_we, cdb_req = 0; issuels_done = 1 in the first cycle after reset is released.
  - Reset mid-operation drops the in-flight op silently: no CDB broadcast, memory request withdrawn next cycle.
- FSM states: IDLE, MEM, WB. All outputs are decoded from registered state and latched fields; there is no combinational path from inputs to outputs.
- IDLE:
  - issuels_done = 1.
  - Accept when issuels_ready = 1: latch opcode, rdtag, addr, data; clear counter; go to MEM.
  - Otherwise stay in IDLE.
- MEM:
  - dmem_req = 1, dmem_we = ~opcode, dmem_addr/dmem_wdata = latched values, held stable until ack.
  - issuels_done = 0.
  - dmem_ack = 1 with a store: go to IDLE.
  - dmem_ack = 1 with a load: latch dmem_rdata, go to WB.
  - No ack: counter increments. If counter reaches TIMEOUT-1 without ack, set ls_timeout (sticky until reset), drop the op and go to IDLE; a load's tag is never broadcast.
  - An ack arriving in the same cycle as the timeout threshold wins: no error is raised.
- WB:
  - cdb_req = 1, cdb_out_tag = rdtag, cdb_out_data = latched load data; held stable until grant.
  - issuels_done = 0.
  - cdb_grant = 1: go to IDLE.
  - No timeout is applied in WB; it waits indefinitely.
- Timing:
  - Accept at edge T; dmem_req is high in cycle T+1.
  - Store with 0-wait ack (ack in the first MEM cycle): issuels_done returns high at T+2, giving one op per 2 cycles.
  - Load with 0-wait ack and immediate grant: cdb_req high in cycle T+2, done high at T+3.
- Outputs when not asserted:
  - cdb_out_tag/cdb_out_data are 0 unless in WB.
  - dmem_addr/dmem_wdata are 0 unless in MEM.
  - dmem_we is 0 unless in MEM with a store.
- Ops are processed strictly one at a time in acceptance order; there is no overlap between accesses.

Test Plan:
- Reset held low 3 cycles, then released -> all outputs 0 except issuels_done = 1; ls_timeout = 0.
- Store opcode = 0, addr = 0x0000_1004, data = 0xDEAD_BEEF, dmem_ack on the 1st MEM cycle -> one cycle of dmem_req = 1, dmem_we = 1, addr/wdata matching; no cdb_req; done high 2 cycles after accept.
- Load opcode = 1, rdtag = 0x2A, addr = 0x0000_0040, ack after 3 wait cycles with rdata = 0x1234_5678, cdb_grant delayed 2 cycles -> dmem_req high 4 cycles with we = 0; cdb_req high 3 cycles with tag 0x2A, data 0x1234_5678; done low throughout.
- Back-to-back store then load with issuels_ready held high, 0-wait ack and grant -> second op accepted on the cycle done returns high; order preserved; each address appears exactly once on dmem_addr.
- TIMEOUT = 4, load never acked -> dmem_req high exactly 4 cycles; ls_timeout rises and stays 1; no cdb_req; done = 1 the next cycle; a subsequent store completes normally.
- Reset asserted while in WB with cdb_req = 1 -> cdb_req = 0 the next cycle; no broadcast occurs after release.
